// File: rtl/silu_gelu_pipe.sv
// rtl/silu_gelu_pipe.sv - 3-stage multi-lane SiLU / approximate-GELU activation pipeline (optional SILU_GELU_ROUND_EN)
module silu_gelu_pipe #(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int LANES = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        n_en,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_mode,
    input  logic [LANES*(IL+FL)-1:0]    in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_mode,
    output logic [LANES*(IL+FL)-1:0]    out_data
);
    localparam int W   = IL + FL;
    localparam int AW  = W + 2;       // sigmoid argument, 1.75x never wraps
    localparam int SW  = FL + 1;      // sigmoid value, 0 .. 1.0
    localparam int TW  = FL + 2;      // t, signed, -1.0 .. 0
    localparam int PW  = W + SW + 1;  // x * sig product
    localparam int ONE = 1 << FL;
    localparam logic [AW-1:0] FOUR = AW'(4) << FL;

    logic adv;

    logic                      v1_q, v2_q, v3_q;
    logic                      m1_q, m2_q, m3_q;
    logic [LANES-1:0][AW-1:0]  abs1_d, abs1_q;
    logic [LANES-1:0]          neg1_d, neg1_q, neg2_q;
    logic [LANES-1:0][W-1:0]   x1_q, x2_q;
    logic [LANES-1:0][SW-1:0]  sig2_d, sig2_q;
    logic [LANES-1:0][W-1:0]   y3_d, y3_q;

    logic signed [AW-1:0]      xe_c  [LANES];
    logic signed [AW-1:0]      a_c   [LANES];
    logic [AW-1:0]             s_c   [LANES];
    logic signed [TW-1:0]      t_c   [LANES];
    logic signed [2*TW-1:0]    tt_c  [LANES];
    logic [SW-1:0]             q_c   [LANES];
    logic signed [PW-1:0]      p_c   [LANES];

    // A stall at the output or a disable freezes every stage at once; bubbles are kept.
    assign adv       = !n_en && (!v3_q || out_ready);
    assign in_ready  = adv && !reset;
    assign out_valid = v3_q;
    assign out_mode  = m3_q;
    assign out_data  = y3_q;

    // Stage 1 math: form the sigmoid argument (x or 1.75x) and split it into sign and magnitude.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            xe_c[k]   = AW'($signed(in_data[k*W +: W]));
            a_c[k]    = in_mode ? (xe_c[k] + (xe_c[k] >>> 1) + (xe_c[k] >>> 2)) : xe_c[k];
            neg1_d[k] = a_c[k][AW-1];
            abs1_d[k] = a_c[k][AW-1] ? AW'(-a_c[k]) : AW'(a_c[k]);
        end
    end

    // Stage 2 math: clamp to 4.0, evaluate the quadratic tail q and fold it by sign into sig.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            s_c[k]  = (abs1_q[k] > FOUR) ? FOUR : abs1_q[k];
            t_c[k]  = TW'($signed({1'b0, s_c[k][FL+2:2]}) - ONE);
`ifdef SILU_GELU_ROUND_EN
            tt_c[k] = (t_c[k] * t_c[k]) + (2*TW)'(ONE);
`else
            tt_c[k] = t_c[k] * t_c[k];
`endif
            q_c[k]    = tt_c[k][FL+1 +: SW];
            sig2_d[k] = neg1_q[k] ? q_c[k] : (SW'(ONE) - q_c[k]);
        end
    end

    // Stage 3 math: scale x by sig; the result magnitude never exceeds |x| so W bits suffice.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
`ifdef SILU_GELU_ROUND_EN
            p_c[k] = ($signed(x2_q[k]) * $signed({1'b0, sig2_q[k]})) + PW'(ONE >> 1);
`else
            p_c[k] = $signed(x2_q[k]) * $signed({1'b0, sig2_q[k]});
`endif
            y3_d[k] = p_c[k][FL +: W];
        end
    end

    // Pipeline registers: clear on reset, shift all three stages together on advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            m1_q   <= 1'b0;
            m2_q   <= 1'b0;
            m3_q   <= 1'b0;
            abs1_q <= '0;
            neg1_q <= '0;
            neg2_q <= '0;
            x1_q   <= '0;
            x2_q   <= '0;
            sig2_q <= '0;
            y3_q   <= '0;
        end else if (adv) begin
            v1_q   <= in_valid;
            m1_q   <= in_mode;
            abs1_q <= abs1_d;
            neg1_q <= neg1_d;
            x1_q   <= in_data;
            v2_q   <= v1_q;
            m2_q   <= m1_q;
            neg2_q <= neg1_q;
            x2_q   <= x1_q;
            sig2_q <= sig2_d;
            v3_q   <= v2_q;
            m3_q   <= m2_q;
            y3_q   <= y3_d;
        end
    end
endmodule

// File: tb/tb_silu_gelu_pipe.sv
// tb/tb_silu_gelu_pipe.sv - directed and scoreboard bench for silu_gelu_pipe
module tb_silu_gelu_pipe;
    localparam int IL = 4, FL = 16, LANES = 8;
    localparam int W  = IL + FL;
    localparam int DW = LANES * W;

    logic          clk = 1'b0;
    logic          reset, n_en, in_valid, in_ready, in_mode;
    logic          out_valid, out_ready, out_mode;
    logic [DW-1:0] in_data, out_data;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [DW:0]   sb_q[$];
    real           max_err = 0.0;

    silu_gelu_pipe #(.IL(IL), .FL(FL), .LANES(LANES)) dut (
        .clk(clk), .reset(reset), .n_en(n_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack8(input logic [W-1:0] l0, l1, l2, l3, l4, l5, l6, l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    function automatic logic [W-1:0] ref_y(input logic [W-1:0] xb, input logic mode);
        longint x, a, s, t, q, sig, p, y;
        real    xr, tr, er;
        x = longint'($signed(xb));
        a = mode ? x + (x >>> 1) + (x >>> 2) : x;
        s = (a < 0) ? -a : a;
        if (s > 262144) s = 262144;
        t = s / 4 - 65536;
`ifdef SILU_GELU_ROUND_EN
        q = (t * t + 65536) / 131072;
`else
        q = (t * t) / 131072;
`endif
        sig = (a < 0) ? q : 65536 - q;
        p = x * sig;
`ifdef SILU_GELU_ROUND_EN
        y = (p + 32768) >>> 16;
`else
        y = p >>> 16;
`endif
        xr = real'(x) / 65536.0;
        tr = xr / (1.0 + $exp(-(mode ? 1.75 : 1.0) * xr));
        er = real'(y) / 65536.0 - tr;
        if (er < 0.0) er = -er;
        if (er > max_err) max_err = er;
        return y[W-1:0];
    endfunction

    function automatic logic [DW:0] ref_beat(input logic [DW-1:0] d, input logic mode);
        logic [DW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*W +: W] = ref_y(d[k*W +: W], mode);
        return {mode, r};
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < LANES; k++) begin
            case ($urandom_range(0, 7))
                0:       d[k*W +: W] = 20'h80000;
                1:       d[k*W +: W] = 20'h7FFFF;
                2:       d[k*W +: W] = W'($urandom_range(0, 9)) - 20'd4;
                default: d[k*W +: W] = W'($urandom);
            endcase
        end
        return d;
    endfunction

    // One clock: sample handshakes at the falling edge, keep the scoreboard, return after the rise.
    task automatic cycle(output bit acc, output bit emt);
        logic [DW:0] exp;
        @(negedge clk);
        acc = in_valid && in_ready;
        emt = out_valid && out_ready && !n_en;
        if (reset) begin
            sb_q.delete();
        end else begin
            if (emt) begin
                check("sb_nonempty", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    check("sb_beat", {out_mode, out_data}, exp);
                end
            end
            if (acc) sb_q.push_back(ref_beat(in_data, in_mode));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int nbeats, input int st_lo, input int st_hi,
                          input int ne_lo, input int ne_hi, input bit rnd, input string tag);
        int            sent = 0, rcvd = 0, cyc = 0;
        bit            acc, emt, prev_hold;
        logic [DW:0]   prev_out;
        logic [DW-1:0] cur;
        logic          cm;
        prev_hold = 1'b0;
        prev_out  = '0;
        cur = rand_data();
        cm  = 1'($urandom_range(0, 1));
        while (rcvd < nbeats && cyc < 400) begin
            n_en      = (cyc >= ne_lo && cyc <= ne_hi);
            out_ready = (cyc >= st_lo && cyc <= st_hi) ? 1'b0 :
                        (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_valid  = (sent < nbeats);
            in_data   = cur;
            in_mode   = cm;
            #1;
            check({tag, "_in_ready"}, in_ready, !n_en && (!out_valid || out_ready));
            if (prev_hold) begin
                check({tag, "_hold_valid"}, out_valid, 1);
                check({tag, "_hold_data"}, {out_mode, out_data}, prev_out);
            end
            prev_hold = out_valid && (n_en || !out_ready);
            prev_out  = {out_mode, out_data};
            cycle(acc, emt);
            if (acc) begin
                sent++;
                cur = rand_data();
                cm  = 1'($urandom_range(0, 1));
            end
            if (emt) rcvd++;
            cyc++;
        end
        n_en = 1'b0;
        in_valid = 1'b0;
        check({tag, "_count"}, rcvd, nbeats);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit acc, emt;
        logic [DW-1:0] exp_d;

        reset = 1'b1; n_en = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_mode", out_mode, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Directed SiLU beat with clamp and extreme lanes.
        in_valid = 1'b1; in_mode = 1'b0;
        in_data = pack8(20'h00000, 20'h40000, 20'hC0000, 20'h20000,
                        20'hE0000, 20'h50000, 20'h80000, 20'h7FFFF);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t1_lat1", out_valid, 0);
        @(posedge clk); #1;
        check("t1_lat2", out_valid, 0);
        @(posedge clk); #1;
        check("t1_valid", out_valid, 1);
        check("t1_mode", out_mode, 0);
        exp_d = pack8(20'h00000, 20'h40000, 20'h00000, 20'h1C000,
                      20'hFC000, 20'h50000, 20'h00000, 20'h7FFFF);
        for (int k = 0; k < LANES; k++)
            check($sformatf("t1_lane%0d", k), out_data[k*W +: W], exp_d[k*W +: W]);
        @(posedge clk); #1;
        check("t1_drain", out_valid, 0);

        // Directed GELU-approximation beat.
        in_valid = 1'b1; in_mode = 1'b1;
        in_data = pack8(20'h20000, 20'hE0000, 20'h40000, 20'hC0000, 20'h0, 20'h0, 20'h0, 20'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t2_valid", out_valid, 1);
        check("t2_mode", out_mode, 1);
        exp_d = pack8(20'h1FC00, 20'hFFC00, 20'h40000, 20'h00000, 20'h0, 20'h0, 20'h0, 20'h0);
        for (int k = 0; k < LANES; k++)
            check($sformatf("t2_lane%0d", k), out_data[k*W +: W], exp_d[k*W +: W]);
        @(posedge clk); #1;

        stream(10, 4, 7, -1, -1, 1'b0, "t3_stall");
        stream(10, -1, -1, 3, 5, 1'b0, "t4_nen");

        // Reset with three beats in flight.
        out_ready = 1'b1; n_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mode = 1'($urandom_range(0, 1)); in_data = rand_data();
            cycle(acc, emt);
        end
        reset = 1'b1;
        #1;
        check("t5_in_ready_rst", in_ready, 0);
        cycle(acc, emt);
        check("t5_out_valid", out_valid, 0);
        check("t5_out_data", out_data, 0);
        check("t5_out_mode", out_mode, 0);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        check("t5_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(acc, emt);
            check("t5_no_stale", out_valid, 0);
        end

        stream(60, -1, -1, 20, 22, 1'b1, "t6_rand");

        $display("max abs error vs real activation: %f", max_err);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
